// File: rtl/burst_req_pkg.sv
// burst_req_pkg: shared FSM state type and default sizing for the burst requester
package burst_req_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} state_t;
    localparam int LEN_W_DEF = 3;
    localparam int DEPTH_DEF = 4;
    localparam int GAP_DEF   = 0;
endpackage

// File: rtl/burst_cmd_fifo.sv
// burst_cmd_fifo: DEPTH x W burst command queue with full/empty flags
module burst_cmd_fifo
    import burst_req_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = LEN_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    // storage needs no reset: only slots between rd_ptr and wr_ptr are ever consumed
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/burst_req_gen.sv
// burst_req_gen: queues burst commands, drives req/num_grants to the arbiter and checks gnt/last
module burst_req_gen
    import burst_req_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int GAP   = GAP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             req,
    output logic [LEN_W-1:0] num_grants,
    input  logic             gnt,
    input  logic             last,
    output logic             burst_done,
    output logic [LEN_W-1:0] grant_cnt,
    output logic             busy,
    output logic             err
);
    state_t           state;
    logic [3:0]       gap_cnt;
    logic             full;
    logic             empty;
    logic             pop;
    logic [LEN_W-1:0] head;
    logic             bad;
    burst_cmd_fifo #(.DEPTH(DEPTH), .W(LEN_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .din   (cmd_len),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    assign cmd_ready = !full;
    assign pop       = state == ST_IDLE && !empty;
    assign busy      = state != ST_IDLE || !empty;
    assign bad = (gnt && !req) || (last && !req) || (last && !gnt)
              || (gnt && grant_cnt == num_grants)
              || (last && {1'b0, grant_cnt} + (LEN_W+1)'(1) != {1'b0, num_grants});
    // sequencer: load head in IDLE, hold req until last, then optional idle gap
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state      <= ST_IDLE;
            req        <= 1'b0;
            num_grants <= '0;
            grant_cnt  <= '0;
            burst_done <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                ST_IDLE: if (!empty) begin
                    grant_cnt <= '0;
                    if (head == '0) burst_done <= 1'b1;
                    else begin
                        num_grants <= head;
                        req        <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (gnt && grant_cnt != '1) grant_cnt <= grant_cnt + 1'b1;
                    if (last) begin
                        req        <= 1'b0;
                        burst_done <= 1'b1;
                        gap_cnt    <= '0;
                        state      <= GAP > 0 ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == 4'(GAP - 1)) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    // sticky protocol error, cleared only by reset
    always_ff @(posedge clk or posedge reset)
        if (reset) err <= 1'b0;
        else if (bad) err <= 1'b1;
endmodule

// File: tb/tb_burst_req_gen.sv
// tb_burst_req_gen: randomized arbiter-side bench with a queue-based reference model
module tb_burst_req_gen;
    localparam int LW = 3;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sel = 1'b0;
    logic          cv_d = 1'b0;
    logic [LW-1:0] len_d = '0;
    logic          gnt_d = 1'b0;
    logic          last_d = 1'b0;
    logic          cv_a, cv_b, gnt_a, gnt_b, last_a, last_b;
    logic          rdy_a, rdy_b, req_a, req_b, bd_a, bd_b, busy_a, busy_b, err_a, err_b;
    logic [LW-1:0] ng_a, ng_b, gc_a, gc_b;
    logic          rdy_s, req_s, bd_s, busy_s, err_s;
    logic [LW-1:0] ng_s, gc_s;
    int            checks = 0;
    int            errors = 0;
    always #5 clk = ~clk;
    assign cv_a   = cv_d & ~sel;
    assign cv_b   = cv_d & sel;
    assign gnt_a  = gnt_d & ~sel;
    assign gnt_b  = gnt_d & sel;
    assign last_a = last_d & ~sel;
    assign last_b = last_d & sel;
    assign rdy_s  = sel ? rdy_b : rdy_a;
    assign req_s  = sel ? req_b : req_a;
    assign bd_s   = sel ? bd_b : bd_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign err_s  = sel ? err_b : err_a;
    assign ng_s   = sel ? ng_b : ng_a;
    assign gc_s   = sel ? gc_b : gc_a;
    burst_req_gen #(.DEPTH(4), .LEN_W(LW), .GAP(0)) dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cv_a), .cmd_ready(rdy_a), .cmd_len(len_d),
        .req(req_a), .num_grants(ng_a), .gnt(gnt_a), .last(last_a), .burst_done(bd_a),
        .grant_cnt(gc_a), .busy(busy_a), .err(err_a));
    burst_req_gen #(.DEPTH(4), .LEN_W(LW), .GAP(3)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cv_b), .cmd_ready(rdy_b), .cmd_len(len_d),
        .req(req_b), .num_grants(ng_b), .gnt(gnt_b), .last(last_b), .burst_done(bd_b),
        .grant_cnt(gc_b), .busy(busy_b), .err(err_b));
    // all tasks start and end on a negedge: outputs are read there, inputs driven for the next posedge
    task automatic do_reset();
        reset = 1'b1;
        cv_d = 1'b0;
        gnt_d = 1'b0;
        last_d = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic push(input logic [LW-1:0] l, output bit acc);
        cv_d = 1'b1;
        len_d = l;
        acc = rdy_s;
        @(negedge clk);
        cv_d = 1'b0;
    endtask
    // arbiter model: after req is seen, wait lat cycles, grant n cycles, last on the li-th cycle
    task automatic serve(input int lat, input int n, input int li, output bit to,
                         output int pre, output int hi, output int dn, output logic [LW-1:0] gc);
        int step;
        to = 0; pre = 0; hi = 0; dn = 0; gc = '0; step = 0;
        while (!req_s && pre < 40) begin
            @(negedge clk);
            pre++;
        end
        if (!req_s) begin
            to = 1;
            return;
        end
        while (req_s && step < 40) begin
            hi++;
            dn += int'(bd_s);
            gnt_d = step >= lat && step < lat + n;
            last_d = li != 0 && step == lat + li - 1;
            @(negedge clk);
            step++;
        end
        gnt_d = 1'b0;
        last_d = 1'b0;
        if (req_s) to = 1;
        dn += int'(bd_s);
        gc = gc_s;
    endtask
    task automatic test_reset();
        do_reset();
        checks++; if (req_s !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b exp 0", req_s); end
        checks++; if (ng_s !== '0) begin errors++; $display("FAIL reset_num_grants: got %0d exp 0", ng_s); end
        checks++; if (bd_s !== 1'b0) begin errors++; $display("FAIL reset_burst_done: got %0b exp 0", bd_s); end
        checks++; if (gc_s !== '0) begin errors++; $display("FAIL reset_grant_cnt: got %0d exp 0", gc_s); end
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b exp 0", err_s); end
        checks++; if (rdy_s !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b exp 1", rdy_s); end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy_s); end
    endtask
    task automatic test_single();
        bit acc, to;
        int pre, hi, dn;
        logic [LW-1:0] gc;
        push(2, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL single_accept: got %0b exp 1", acc); end
        serve(1, 2, 2, to, pre, hi, dn, gc);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout: got %0b exp 0", to); end
        checks++; if (hi != 3) begin errors++; $display("FAIL single_req_high: got %0d exp 3", hi); end
        checks++; if (dn != 1) begin errors++; $display("FAIL single_done: got %0d exp 1", dn); end
        checks++; if (gc !== 3'd2) begin errors++; $display("FAIL single_grant_cnt: got %0d exp 2", gc); end
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL single_err: got %0b exp 0", err_s); end
        @(negedge clk);
        checks++; if (bd_s !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %0b exp 0", bd_s); end
        checks++; if (ng_s !== 3'd2) begin errors++; $display("FAIL single_ng_hold: got %0d exp 2", ng_s); end
    endtask
    task automatic test_back_to_back();
        bit acc, to;
        int pre, hi, dn, lat, exp_len;
        logic [LW-1:0] gc;
        int lens[4] = '{2, 3, 1, 2};
        int q[$];
        push(2, acc);
        q.push_back(2);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            push(LW'(lens[i]), acc);
            q.push_back(lens[i]);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_accept%0d: got %0b exp 1", i, acc); end
        end
        checks++; if (rdy_s !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %0b exp 0", rdy_s); end
        push(1, acc);
        checks++; if (acc !== 1'b0) begin errors++; $display("FAIL b2b_fifth_held: got %0b exp 0", acc); end
        for (int i = 0; i < 5; i++) begin
            exp_len = q.pop_front();
            lat = $urandom_range(0, 2);
            serve(lat, exp_len, exp_len, to, pre, hi, dn, gc);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL b2b_timeout%0d: got %0b exp 0", i, to); end
            checks++; if (gc !== LW'(exp_len)) begin errors++; $display("FAIL b2b_grant_cnt%0d: got %0d exp %0d", i, gc, exp_len); end
            if (i > 0) begin
                checks++; if (pre != 1) begin errors++; $display("FAIL b2b_low_gap%0d: got %0d exp 1", i, pre); end
                checks++; if (hi != lat + exp_len) begin errors++; $display("FAIL b2b_req_high%0d: got %0d exp %0d", i, hi, lat + exp_len); end
            end
        end
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL b2b_err: got %0b exp 0", err_s); end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %0b exp 0", busy_s); end
    endtask
    task automatic test_random();
        bit acc, to;
        int pre, hi, dn, lat, n, exp_len;
        logic [LW-1:0] gc;
        int q[$];
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                exp_len = $urandom_range(1, 7);
                push(LW'(exp_len), acc);
                q.push_back(exp_len);
            end
            while (q.size() > 0) begin
                exp_len = q.pop_front();
                lat = $urandom_range(0, 2);
                serve(lat, exp_len, exp_len, to, pre, hi, dn, gc);
                checks++; if (gc !== LW'(exp_len) || to) begin errors++; $display("FAIL rand_grant_cnt: got %0d exp %0d", gc, exp_len); end
                checks++; if (hi != lat + exp_len) begin errors++; $display("FAIL rand_req_high: got %0d exp %0d", hi, lat + exp_len); end
                checks++; if (dn != 1) begin errors++; $display("FAIL rand_done: got %0d exp 1", dn); end
            end
        end
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL rand_err: got %0b exp 0", err_s); end
    endtask
    task automatic test_protocol_err();
        bit acc, to;
        int pre, hi, dn;
        logic [LW-1:0] gc;
        push(2, acc);
        serve(0, 1, 1, to, pre, hi, dn, gc);
        checks++; if (hi != 1 || to) begin errors++; $display("FAIL early_last_req_high: got %0d exp 1", hi); end
        checks++; if (gc !== 3'd1) begin errors++; $display("FAIL early_last_grant_cnt: got %0d exp 1", gc); end
        checks++; if (err_s !== 1'b1) begin errors++; $display("FAIL early_last_err: got %0b exp 1", err_s); end
        push(1, acc);
        serve(0, 1, 1, to, pre, hi, dn, gc);
        checks++; if (err_s !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b exp 1", err_s); end
        do_reset();
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL err_reset_clear: got %0b exp 0", err_s); end
        push(1, acc);
        serve(0, 2, 2, to, pre, hi, dn, gc);
        checks++; if (err_s !== 1'b1) begin errors++; $display("FAIL overrun_err: got %0b exp 1", err_s); end
        checks++; if (hi != 2 || gc !== 3'd2) begin errors++; $display("FAIL overrun_shape: got hi %0d gc %0d exp hi 2 gc 2", hi, gc); end
        do_reset();
        push(2, acc);
        serve(0, 1, 2, to, pre, hi, dn, gc);
        checks++; if (err_s !== 1'b1) begin errors++; $display("FAIL last_no_gnt_err: got %0b exp 1", err_s); end
        checks++; if (gc !== 3'd1) begin errors++; $display("FAIL last_no_gnt_grant_cnt: got %0d exp 1", gc); end
        do_reset();
    endtask
    task automatic test_idle_and_zero();
        bit acc, to;
        int pre, hi, dn;
        logic [LW-1:0] gc;
        push(3, acc);
        serve(0, 3, 3, to, pre, hi, dn, gc);
        checks++; if (gc !== 3'd3) begin errors++; $display("FAIL zero_pre_grant_cnt: got %0d exp 3", gc); end
        push(0, acc);
        @(negedge clk);
        checks++; if (bd_s !== 1'b1) begin errors++; $display("FAIL zero_done: got %0b exp 1", bd_s); end
        checks++; if (gc_s !== '0) begin errors++; $display("FAIL zero_grant_cnt: got %0d exp 0", gc_s); end
        checks++; if (req_s !== 1'b0) begin errors++; $display("FAIL zero_req0: got %0b exp 0", req_s); end
        @(negedge clk);
        checks++; if (bd_s !== 1'b0 || req_s !== 1'b0) begin errors++; $display("FAIL zero_after: got done %0b req %0b exp 0 0", bd_s, req_s); end
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL zero_err: got %0b exp 0", err_s); end
        gnt_d = 1'b1;
        @(negedge clk);
        gnt_d = 1'b0;
        checks++; if (err_s !== 1'b1) begin errors++; $display("FAIL idle_gnt_err: got %0b exp 1", err_s); end
        do_reset();
    endtask
    task automatic test_async_reset();
        bit acc, seen;
        gnt_d = 1'b1;
        @(negedge clk);
        gnt_d = 1'b0;
        push(3, acc);
        push(2, acc);
        push(1, acc);
        gnt_d = 1'b1;
        @(negedge clk);
        gnt_d = 1'b0;
        checks++; if (req_s !== 1'b1 || gc_s !== 3'd1 || err_s !== 1'b1) begin errors++; $display("FAIL areset_pre: got req %0b gc %0d err %0b exp 1 1 1", req_s, gc_s, err_s); end
        #2 reset = 1'b1;
        #1;
        checks++; if (req_s !== 1'b0) begin errors++; $display("FAIL areset_req: got %0b exp 0", req_s); end
        checks++; if (err_s !== 1'b0 || bd_s !== 1'b0) begin errors++; $display("FAIL areset_err_done: got %0b %0b exp 0 0", err_s, bd_s); end
        checks++; if (rdy_s !== 1'b1 || busy_s !== 1'b0) begin errors++; $display("FAIL areset_fifo: got ready %0b busy %0b exp 1 0", rdy_s, busy_s); end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen |= req_s;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL areset_flushed: got req seen %0b exp 0", seen); end
    endtask
    task automatic test_gap();
        bit acc, to;
        int pre, hi, dn;
        logic [LW-1:0] gc;
        sel = 1'b1;
        push(1, acc);
        push(2, acc);
        serve(0, 1, 1, to, pre, hi, dn, gc);
        checks++; if (to !== 1'b0 || gc !== 3'd1) begin errors++; $display("FAIL gap_first: got to %0b gc %0d exp 0 1", to, gc); end
        serve(0, 2, 2, to, pre, hi, dn, gc);
        checks++; if (pre != 4) begin errors++; $display("FAIL gap_low_cycles: got %0d exp 4", pre); end
        checks++; if (gc !== 3'd2 || hi != 2 || to) begin errors++; $display("FAIL gap_second: got gc %0d hi %0d exp 2 2", gc, hi); end
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL gap_err: got %0b exp 0", err_s); end
        sel = 1'b0;
    endtask
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_protocol_err();
        test_idle_and_zero();
        test_async_reset();
        test_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
